// File: rtl/decode_issue_controller.sv
// IF/ID register and issue control with RAW hazard detection, branch flush and memory freeze.
// Optional macro DECODE_ISSUE_FWD_EN: EX/MEM forwarding present, only load-use stalls.
module decode_issue_controller #(
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  output logic                   if_ready,
  output logic                   id_valid,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  input  logic                   mem_stall,
  input  logic                   br_taken,
  output logic                   issue,
  output logic                   bubble,
  output logic [1:0]             ctrl_state,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZARD = 2'd1,
    ST_FREEZE = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       is_load;
  } shadow_t;

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {OP_BR, OP_STORE, OP_REG};
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
  endfunction

  // x0 sources are filtered by the live flags, rd=0 producers by the stage check.
  function automatic logic stage_hit(input shadow_t s, input logic [4:0] a, input logic a_live,
                                     input logic [4:0] b, input logic b_live);
    return s.v && (s.rd != 5'd0) && ((a_live && s.rd == a) || (b_live && s.rd == b));
  endfunction

  state_e                 state_q, state_d;
  shadow_t                ex_q, mem_q, wb_q, id_entry;
  logic                   valid_q;
  logic [31:0]            instr_q, pc_q;
  logic [STALL_CNT_W-1:0] cnt_q;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs1_live, rs2_live, hazard;

  assign opcode   = instr_q[6:0];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign rs1_live = reads_rs1(opcode) && (rs1 != 5'd0);
  assign rs2_live = reads_rs2(opcode) && (rs2 != 5'd0);
  assign id_entry = '{v: writes_rd(opcode), rd: instr_q[11:7], is_load: (opcode == OP_LOAD)};

`ifdef DECODE_ISSUE_FWD_EN
  assign hazard = valid_q && ex_q.is_load && stage_hit(ex_q, rs1, rs1_live, rs2, rs2_live);
`else
  assign hazard = valid_q && (stage_hit(ex_q,  rs1, rs1_live, rs2, rs2_live) ||
                              stage_hit(mem_q, rs1, rs1_live, rs2, rs2_live) ||
                              stage_hit(wb_q,  rs1, rs1_live, rs2, rs2_live));
`endif

  assign issue       = valid_q & ~hazard & ~mem_stall & ~br_taken;
  assign bubble      = ~mem_stall & ~issue;
  assign if_ready    = ~mem_stall & (~valid_q | issue | br_taken);
  assign id_valid    = valid_q;
  assign id_instr    = valid_q ? instr_q : NOP_INSTR;
  assign id_pc       = pc_q;
  assign ctrl_state  = state_q;
  assign stall_count = cnt_q;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = ST_RUN;
    if (mem_stall)     state_d = ST_FREEZE;
    else if (br_taken) state_d = ST_FLUSH;
    else if (hazard)   state_d = ST_HAZARD;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else if (!mem_stall) begin
      ex_q  <= issue ? id_entry : '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;

      if (hazard && !br_taken && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;

      // A word fetched alongside a taken branch is wrong-path and dropped.
      if (br_taken) begin
        valid_q <= 1'b0;
      end else if (if_valid && if_ready) begin
        valid_q <= 1'b1;
        instr_q <= if_instr;
        pc_q    <= if_pc;
      end else if (issue) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_controller.sv
// Self-checking bench for decode_issue_controller: directed scenarios plus randomized
// traffic against a history-based reference model; follows DECODE_ISSUE_FWD_EN.
module tb_decode_issue_controller;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] LW     = 32'h0000_A283;  // lw   x5,0(x1)
  localparam logic [31:0] ADD5   = 32'h0072_8333;  // add  x6,x5,x7
  localparam logic [31:0] ADDI1  = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] ADD11  = 32'h0010_8133;  // add  x2,x1,x1
  localparam logic [31:0] ADD00  = 32'h0000_0333;  // add  x6,x0,x0
  localparam logic [31:0] ADDI3  = 32'h0030_0193;  // addi x3,x0,3
  localparam logic [31:0] ADDI7  = 32'h0070_0393;  // addi x7,x0,7
  localparam logic [31:0] ADDI4  = 32'h0050_0213;  // addi x4,x0,5
`ifdef DECODE_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int RAW_STALLS = FWD ? 0 : 3;
  localparam int LU_STALLS  = FWD ? 1 : 3;

  logic        clk, rst, if_valid, if_ready, id_valid, mem_stall, br_taken, issue, bubble;
  logic [31:0] if_instr, if_pc, id_instr, id_pc;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;
  int exp_total = 0;

  decode_issue_controller dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .mem_stall(mem_stall), .br_taken(br_taken), .issue(issue), .bubble(bubble),
    .ctrl_state(ctrl_state), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_hist[i] = register write of the instruction that entered EX i+1 unfrozen cycles ago.
  typedef struct packed {logic v; logic [4:0] rd; logic ld;} wr_t;
  logic        m_idv;
  logic [31:0] m_instr, m_pc;
  wr_t         m_hist [3];
  logic [1:0]  m_state;
  int unsigned m_cnt;
  logic        m_hz, e_issue, e_bubble, e_ready;
  logic [3:0]  m_kind;

  // {reads rs1, reads rs2, writes rd, is load}
  function automatic logic [3:0] kind(input logic [31:0] w);
    case (w[6:0])
      7'h37, 7'h17, 7'h6F: return 4'b0010;
      7'h67:               return 4'b1010;
      7'h63, 7'h23:        return 4'b1100;
      7'h03:               return 4'b1011;
      7'h13:               return 4'b1010;
      7'h33:               return 4'b1110;
      default:             return 4'b0000;
    endcase
  endfunction

  always_comb begin
    m_kind = kind(m_instr);
    m_hz   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_idv && (i < (FWD ? 1 : 3)) && m_hist[i].v && m_hist[i].rd != 5'd0 &&
          (!FWD || m_hist[i].ld)) begin
        if (m_kind[3] && m_instr[19:15] == m_hist[i].rd) m_hz = 1'b1;
        if (m_kind[2] && m_instr[24:20] == m_hist[i].rd) m_hz = 1'b1;
      end
    end
    e_issue  = m_idv && !m_hz && !mem_stall && !br_taken;
    e_bubble = !mem_stall && !e_issue;
    e_ready  = !mem_stall && (!m_idv || e_issue || br_taken);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_idv   <= 1'b0;
      m_instr <= NOP;
      m_pc    <= 32'd0;
      m_state <= 2'd0;
      m_cnt   <= 0;
      for (int i = 0; i < 3; i++) m_hist[i] <= '0;
    end else begin
      m_state <= mem_stall ? 2'd2 : br_taken ? 2'd3 : m_hz ? 2'd1 : 2'd0;
      if (!mem_stall) begin
        m_hist[2] <= m_hist[1];
        m_hist[1] <= m_hist[0];
        m_hist[0] <= e_issue ? {m_kind[1], m_instr[11:7], m_kind[0]} : '0;
        if (m_hz && !br_taken && m_cnt < 65535) m_cnt <= m_cnt + 1;
        if (br_taken) m_idv <= 1'b0;
        else if (if_valid && e_ready) begin
          m_idv   <= 1'b1;
          m_instr <= if_instr;
          m_pc    <= if_pc;
        end else if (e_issue) m_idv <= 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ms, input logic br);
    @(posedge clk);
    #1;
    if_valid = v; if_instr = w; if_pc = pc; mem_stall = ms; br_taken = br;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Counts non-issuing cycles of the held instruction until it issues; -1 on timeout.
  task automatic count_stalls(output int stalls);
    int guard;
    stalls = 0;
    guard  = 0;
    while (!issue && guard < 12) begin
      stalls++;
      guard++;
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    end
    if (!issue) stalls = -1;
  endtask

  task automatic measure_pair(input logic [31:0] w0, input logic [31:0] w1,
                              output int stalls, output logic first_issued);
    idle(8);
    step(1'b1, w0, 32'h400, 1'b0, 1'b0);
    step(1'b1, w1, 32'h404, 1'b0, 1'b0);
    first_issued = issue;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    count_stalls(stalls);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    step(1'b1, ADDI1, 32'h80, 1'b0, 1'b0);
    step(1'b1, ADDI1, 32'h80, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_during id_valid got=%0b exp=0", id_valid); end
    rst = 1'b0; if_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, NOP); end
    checks++; if (id_pc !== 32'd0) begin errors++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL reset_ctrl_state got=%0d exp=0", ctrl_state); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
  endtask

  task automatic test_load_use;
    int stalls;
    idle(8);
    step(1'b1, LW, 32'h100, 1'b0, 1'b0);
    step(1'b1, ADD5, 32'h104, 1'b0, 1'b0);
    checks++; if (issue !== 1'b1 || id_instr !== LW) begin errors++; $display("FAIL lu_load_issue got issue=%0b instr=%h exp issue=1 instr=%h", issue, id_instr, LW); end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if (issue !== 1'b0 || bubble !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_outputs got issue=%0b bubble=%0b if_ready=%0b exp 0/1/0", issue, bubble, if_ready); end
    checks++; if (id_instr !== ADD5 || id_pc !== 32'h104) begin errors++; $display("FAIL lu_id_held got=%h@%h exp=%h@104", id_instr, id_pc, ADD5); end
    count_stalls(stalls);
    exp_total += LU_STALLS;
    checks++; if (stalls != LU_STALLS) begin errors++; $display("FAIL lu_stall_cycles got=%0d exp=%0d", stalls, LU_STALLS); end
    checks++; if (stall_count !== exp_total[15:0]) begin errors++; $display("FAIL lu_stall_count got=%0d exp=%0d", stall_count, exp_total); end
    checks++; if (ctrl_state !== 2'd1) begin errors++; $display("FAIL lu_ctrl_state got=%0d exp=1", ctrl_state); end
  endtask

  task automatic test_raw;
    int stalls;
    logic first;
    measure_pair(ADDI1, ADD11, stalls, first);
    exp_total += RAW_STALLS;
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL raw_first_issue got=%0b exp=1", first); end
    checks++; if (stalls != RAW_STALLS) begin errors++; $display("FAIL raw_stall_cycles got=%0d exp=%0d", stalls, RAW_STALLS); end
    checks++; if (stall_count !== exp_total[15:0]) begin errors++; $display("FAIL raw_stall_count got=%0d exp=%0d", stall_count, exp_total); end
  endtask

  task automatic test_x0;
    int stalls;
    logic first;
    measure_pair(NOP, ADD00, stalls, first);
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL x0_first_issue got=%0b exp=1", first); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL x0_stall_cycles got=%0d exp=0", stalls); end
    checks++; if (stall_count !== exp_total[15:0]) begin errors++; $display("FAIL x0_stall_count got=%0d exp=%0d", stall_count, exp_total); end
  endtask

  task automatic test_flush;
    idle(8);
    step(1'b1, ADDI3, 32'h200, 1'b0, 1'b0);
    step(1'b1, ADDI7, 32'h204, 1'b0, 1'b1);
    checks++; if (issue !== 1'b0 || bubble !== 1'b1) begin errors++; $display("FAIL flush_outputs got issue=%0b bubble=%0b exp 0/1", issue, bubble); end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin errors++; $display("FAIL flush_id_cleared got valid=%0b instr=%h exp 0/%h", id_valid, id_instr, NOP); end
    checks++; if (ctrl_state !== 2'd3) begin errors++; $display("FAIL flush_ctrl_state got=%0d exp=3", ctrl_state); end
    step(1'b1, ADDI4, 32'h300, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if (issue !== 1'b1 || id_instr !== ADDI4 || id_pc !== 32'h300) begin errors++; $display("FAIL flush_refetch got issue=%0b instr=%h pc=%h exp 1/%h/300", issue, id_instr, id_pc, ADDI4); end
  endtask

  task automatic test_freeze;
    int stalls;
    idle(8);
    step(1'b1, LW, 32'h500, 1'b0, 1'b0);
    step(1'b1, ADD5, 32'h504, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ADDI7, 32'h508, 1'b1, 1'b0);
      checks++; if (issue !== 1'b0 || bubble !== 1'b0 || if_ready !== 1'b0) begin errors++; $display("FAIL freeze_outputs[%0d] got issue=%0b bubble=%0b if_ready=%0b exp 0/0/0", i, issue, bubble, if_ready); end
      checks++; if (id_instr !== ADD5 || id_pc !== 32'h504 || stall_count !== exp_total[15:0]) begin errors++; $display("FAIL freeze_hold[%0d] got %h@%h cnt=%0d exp %h@504 cnt=%0d", i, id_instr, id_pc, stall_count, ADD5, exp_total); end
      if (i > 0) begin
        checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL freeze_ctrl_state[%0d] got=%0d exp=2", i, ctrl_state); end
      end
    end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    count_stalls(stalls);
    exp_total += LU_STALLS;
    checks++; if (stalls != LU_STALLS) begin errors++; $display("FAIL freeze_release_stalls got=%0d exp=%0d", stalls, LU_STALLS); end
    checks++; if (stall_count !== exp_total[15:0]) begin errors++; $display("FAIL freeze_stall_count got=%0d exp=%0d", stall_count, exp_total); end
  endtask

  task automatic test_random;
    logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
    logic [31:0] w;
    for (int n = 0; n < 500; n++) begin
      w        = $urandom;
      w[6:0]   = ops[$urandom_range(0, 9)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 99) < 2);
      if_valid  = ($urandom_range(0, 99) < 70);
      if_instr  = w;
      if_pc     = $urandom;
      mem_stall = ($urandom_range(0, 99) < 15);
      br_taken  = ($urandom_range(0, 99) < 10);
      @(negedge clk);
      checks++; if (issue !== e_issue || bubble !== e_bubble || if_ready !== e_ready) begin errors++; $display("FAIL rand_ctrl[%0d] got issue=%0b bubble=%0b ready=%0b exp %0b/%0b/%0b", n, issue, bubble, if_ready, e_issue, e_bubble, e_ready); end
      checks++; if (id_valid !== m_idv || id_instr !== (m_idv ? m_instr : NOP)) begin errors++; $display("FAIL rand_id[%0d] got valid=%0b instr=%h exp %0b/%h", n, id_valid, id_instr, m_idv, m_idv ? m_instr : NOP); end
      if (m_idv) begin
        checks++; if (id_pc !== m_pc) begin errors++; $display("FAIL rand_pc[%0d] got=%h exp=%h", n, id_pc, m_pc); end
      end
      checks++; if (ctrl_state !== m_state || stall_count !== m_cnt[15:0]) begin errors++; $display("FAIL rand_state[%0d] got state=%0d cnt=%0d exp %0d/%0d", n, ctrl_state, stall_count, m_state, m_cnt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; mem_stall = 1'b0; br_taken = 1'b0;
    test_reset;
    test_load_use;
    test_raw;
    test_x0;
    test_flush;
    test_freeze;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout exp=finish got=hang");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_issue_controller.md
Name: decode_issue_controller

Overview:
- Owns the IF/ID instruction register.
- Presents the held instruction to the instruction decoder and decides each cycle whether it issues into EX or is held.
- Keeps a shadow of the destination registers in EX/MEM/WB and detects RAW hazards using decoder-format fields (opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20]).
- Inserts bubbles, handles branch flush and global memory freeze, and counts hazard stall cycles.

Parameters:
- NOP_INSTR, 32'h00000013, instruction word driven on id_instr when ID holds nothing.
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  fetched instruction word
- if_pc  in  32  PC of the fetched instruction
- if_ready  out  1  controller accepts if_instr this cycle
- id_valid  out  1  ID register holds a live instruction
- id_instr  out  32  word to instruction decoder (NOP_INSTR when !id_valid)
- id_pc  out  32  PC of the ID instruction
- mem_stall  in  1  global freeze (memory not ready); all state holds
- br_taken  in  1  EX resolved a taken branch/jump; flush ID
- issue  out  1  ID instruction moves into EX at this edge
- bubble  out  1  EX receives a NOP at this edge
- ctrl_state  out  2  0=RUN, 1=HAZARD, 2=FREEZE, 3=FLUSH (registered cause of the previous cycle)
- stall_count  out  STALL_CNT_W  hazard-stall cycles, saturating

Behaviour:
- Reset values: id_valid=0, id_instr=NOP_INSTR, id_pc=0, shadows invalid, ctrl_state=RUN, stall_count=0.
- Source-use decode:
  - rs1 is used by JALR, BR, LOAD, STORE, IMM, REG.
  - rs2 is used by BR, STORE, REG.
  - rd is written by LUI, AUIPC, JAL, JALR, LOAD, IMM, REG.
  - rd=0 is never a hazard source; a source register of x0 never matches.
- Shadow pipeline: three entries {v, rd, is_load} for EX, MEM, WB.
  - Advances only when !mem_stall: EX<=issue ? ID fields : invalid; MEM<=EX; WB<=MEM.
- hazard (combinational):
  - Requires id_valid and a used, nonzero source that matches the rd of a valid shadow stage.
  - The stages checked depend on the optional feature below.
- issue = id_valid & !hazard & !mem_stall & !br_taken.
- bubble = !mem_stall & !issue.
- if_ready = !mem_stall & (!id_valid | issue | br_taken).
- ID register update, in priority order:
  1. mem_stall: hold everything.
  2. br_taken: id_valid<=0; any word accepted this cycle is discarded (wrong path).
  3. if_valid & if_ready: load if_instr/if_pc, id_valid<=1.
  4. issue without a new fetch: id_valid<=0.
  5. Otherwise hold.
- Latency:
  - A word accepted at edge N is on id_* during cycle N+1.
  - Its earliest issue is cycle N+1, so back-to-back issue is 1 instruction/cycle.
- br_taken during mem_stall is ignored; EX holds the branch, so br_taken persists until the freeze ends.
- ctrl_state next value, in priority order: mem_stall→FREEZE, br_taken→FLUSH, hazard→HAZARD, else RUN.
- stall_count increments when hazard & !mem_stall & !br_taken, and saturates at all-ones.
- rst asserted mid-stall or mid-freeze returns every register to its reset value at the next edge, regardless of mem_stall.

Optional Feature:
- Macro: DECODE_ISSUE_FWD_EN.
- Defined (EX/MEM forwarding present in the datapath):
  - Hazard only when EX.v & EX.is_load & EX.rd matches (load-use).
  - Exactly 1 bubble per load-use.
- Undefined (no forwarding; register file not write-through):
  - Hazard when any valid EX, MEM or WB rd matches.
  - A dependent instruction following directly stalls 3 cycles.

Test Plan:
- Reset: hold rst 2 cycles with if_valid=1 → id_valid=0, id_instr=32'h00000013, stall_count=0, ctrl_state=0, if_ready=1 after release.
- Load-use, FWD_EN defined: 0x0000A283 (lw x5,0(x1)) then 0x00728333 (add x6,x5,x7):
  - Exactly one cycle with hazard, bubble=1, issue=0, if_ready=0.
  - add issues the next cycle; stall_count=1.
- RAW, FWD_EN undefined: 0x00100093 (addi x1,x0,1) then 0x00108133 (add x2,x1,x1):
  - add stalls 3 cycles with bubble=1; stall_count=3.
  - With FWD_EN defined: 0 stalls.
- x0 immunity: 0x00000013 then 0x00000333 (add x6,x0,x0) → no stall in either build; issue on consecutive cycles.
- Flush: an instruction is in ID when br_taken=1 with if_valid=1 → issue=0, bubble=1, id_valid=0 next cycle, ctrl_state=3; the next fetched word issues normally.
- Freeze: mem_stall=1 for 4 cycles during a load-use hazard:
  - id_*, shadows and stall_count hold; if_ready=0, issue=0, bubble=0, ctrl_state=2.
  - After release the hazard resolves with exactly 1 counted stall (FWD_EN defined).
